// File: rtl/mc_cpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset core.
package mc_cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multi_cycle_cpu_if.sv
// Instruction and data memory req/ready bus of the multi-cycle core.
interface multi_cycle_cpu_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  imem_ready_i, imem_rdata_i, dmem_ready_i, dmem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output imem_ready_i, imem_rdata_i, dmem_ready_i, dmem_rdata_i
    );
endinterface

// File: rtl/mc_cpu_alu.sv
// Combinational ALU shared by every instruction class of the core.
module mc_cpu_alu
    import mc_cpu_pkg::*;
(
    input  alu_op_e     ctrl,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = src1 + src2;
            ALU_SUB: result = src1 - src2;
            ALU_AND: result = src1 & src2;
            ALU_OR:  result = src1 | src2;
            ALU_SLT: result = {31'b0, ($signed(src1) < $signed(src2))};
            ALU_SLL: result = src2 << shamt;
            ALU_SRL: result = src2 >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'h0);
endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one ALU and register file reused across
// FETCH/DECODE/EXEC/MEM/WB, memories reached through req/ready handshakes.
module multi_cycle_cpu
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multi_cycle_cpu_if.master bus,
    output logic              halt_o,
    output logic              illegal_o,
    output logic [31:0]       pc_o
);
    localparam int unsigned RAW = $clog2(NUM_REGS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, target_q, alu_out_q, mdr_q;
    logic [31:0] regs_q [NUM_REGS];
    logic        imem_req_q, dmem_req_q, dmem_we_q, halt_q, illegal_q;

    logic [5:0]     opcode, funct;
    logic [4:0]     shamt;
    logic [RAW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
    logic [31:0]    imm_sext, imm_zext, pc_plus4, br_target, j_target, wb_data;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign shamt    = ir_q[10:6];
    assign rs_idx   = ir_q[21 +: RAW];
    assign rt_idx   = ir_q[16 +: RAW];
    assign rd_idx   = ir_q[11 +: RAW];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign br_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign j_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign wr_idx   = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_out_q;

    // Instruction decode: ALU control, operand selection and legality.
    logic    legal_c, use_imm_c, zext_c, is_halt_c, illegal_trap_c;
    alu_op_e alu_op_c;

    always_comb begin
        legal_c   = 1'b1;
        use_imm_c = 1'b1;
        zext_c    = 1'b0;
        alu_op_c  = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                use_imm_c = 1'b0;
                case (funct)
                    FN_ADD:  alu_op_c = ALU_ADD;
                    FN_SUB:  alu_op_c = ALU_SUB;
                    FN_AND:  alu_op_c = ALU_AND;
                    FN_OR:   alu_op_c = ALU_OR;
                    FN_SLT:  alu_op_c = ALU_SLT;
                    FN_SLL:  alu_op_c = ALU_SLL;
                    FN_SRL:  alu_op_c = ALU_SRL;
                    default: legal_c  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op_c = ALU_ADD;
            OP_SLTI:               alu_op_c = ALU_SLT;
            OP_ORI: begin
                alu_op_c = ALU_OR;
                zext_c   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op_c  = ALU_SUB;
                use_imm_c = 1'b0;
            end
            OP_J:    alu_op_c = ALU_ADD;
            default: legal_c  = 1'b0;
        endcase
    end

    assign is_halt_c      = (opcode == HALT_OP);
    assign illegal_trap_c = (state_q == ST_DECODE) && !is_halt_c && !legal_c;

    logic [31:0] alu_src2, alu_result;
    logic        alu_zero;

    assign alu_src2 = use_imm_c ? (zext_c ? imm_zext : imm_sext) : b_q;

    mc_cpu_alu u_alu (
        .ctrl   (alu_op_c),
        .src1   (a_q),
        .src2   (alu_src2),
        .shamt  (shamt),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // A ready only counts while this core is actually requesting.
    logic fetch_done, mem_done;
    assign fetch_done = (state_q == ST_FETCH) && imem_req_q && bus.imem_ready_i;
    assign mem_done   = (state_q == ST_MEM) && dmem_req_q && bus.dmem_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halt_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == ST_FETCH);
            dmem_req_q <= (state_d == ST_MEM);
            dmem_we_q  <= (state_d == ST_MEM) && (opcode == OP_SW);
            halt_q     <= (state_d == ST_HALT);
            illegal_q  <= illegal_q | illegal_trap_c;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (fetch_done) state_d = ST_DECODE;
            ST_DECODE: state_d = (is_halt_c || !legal_c) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_BEQ, OP_BNE, OP_J: state_d = ST_FETCH;
                    OP_LW, OP_SW:         state_d = ST_MEM;
                    default:              state_d = ST_WB;
                endcase
            end
            ST_MEM:  if (mem_done) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Datapath registers and register file, sequenced by the current state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            target_q  <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                ST_FETCH: if (fetch_done) ir_q <= bus.imem_rdata_i;
                ST_DECODE: begin
                    a_q      <= regs_q[rs_idx];
                    b_q      <= regs_q[rt_idx];
                    target_q <= br_target;
                end
                ST_EXEC: begin
                    alu_out_q <= alu_result;
                    case (opcode)
                        OP_BEQ:  pc_q <= alu_zero ? target_q : pc_plus4;
                        OP_BNE:  pc_q <= alu_zero ? pc_plus4 : target_q;
                        OP_J:    pc_q <= j_target;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (mem_done) begin
                        if (opcode == OP_SW) pc_q <= pc_plus4;
                        else                 mdr_q <= bus.dmem_rdata_i;
                    end
                end
                ST_WB: begin
                    if (wr_idx != '0) regs_q[wr_idx] <= wb_data;
                    pc_q <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_o   = imem_req_q;
    assign bus.imem_addr_o  = pc_q;
    assign bus.dmem_req_o   = dmem_req_q;
    assign bus.dmem_we_o    = dmem_we_q;
    assign bus.dmem_addr_o  = alu_out_q;
    assign bus.dmem_wdata_o = b_q;
    assign halt_o           = halt_q;
    assign illegal_o        = illegal_q;
    assign pc_o             = pc_q;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed program bench for multi_cycle_cpu with wait-state memory models.
module tb_multi_cycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt, illegal;
    logic [31:0] pc;

    multi_cycle_cpu_if bus ();

    multi_cycle_cpu #(.RESET_PC(32'h100)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .halt_o    (halt),
        .illegal_o (illegal),
        .pc_o      (pc)
    );

    initial forever #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    logic        i_rdy = 1'b0, d_rdy = 1'b0, d_force = 1'b0;
    logic [31:0] i_rdata = '0, d_rdata = '0;
    int          imem_wait = 0, dmem_wait = 0;
    logic        clr_log = 1'b1;

    assign bus.imem_ready_i = i_rdy;
    assign bus.imem_rdata_i = i_rdata;
    assign bus.dmem_ready_i = d_rdy | d_force;
    assign bus.dmem_rdata_i = d_rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responders plus a log of fetch starts and data-access stability.
    logic [31:0] fetch_pc [64];
    int          fetch_cyc [64];
    int          nfetch = 0, icnt = 0, dcnt = 0, dacc = 0, d_unstable = 0, req_in_halt = 0;
    logic        ireq_prev = 1'b0;
    logic [31:0] d_addr0 = '0, d_wdata0 = '0, sw_addr = '0, sw_wdata = '0;
    logic        d_we0 = 1'b0, sw_we = 1'b0;

    always @(negedge clk) begin
        if (clr_log) begin
            nfetch = 0; dacc = 0; d_unstable = 0; req_in_halt = 0;
        end
        if (bus.imem_req_o) begin
            if (!ireq_prev && nfetch < 64) begin
                fetch_pc[nfetch]  = bus.imem_addr_o;
                fetch_cyc[nfetch] = cyc;
                nfetch++;
            end
            i_rdy   = (icnt >= imem_wait);
            i_rdata = imem[bus.imem_addr_o[9:2]];
            icnt++;
        end else begin
            i_rdy = 1'b0;
            icnt  = 0;
        end
        ireq_prev = bus.imem_req_o;
        if (bus.dmem_req_o) begin
            if (dcnt == 0) begin
                d_addr0 = bus.dmem_addr_o; d_we0 = bus.dmem_we_o; d_wdata0 = bus.dmem_wdata_o;
                if (dacc == 0) begin
                    sw_addr = bus.dmem_addr_o; sw_we = bus.dmem_we_o; sw_wdata = bus.dmem_wdata_o;
                end
                dacc++;
            end else if (bus.dmem_addr_o != d_addr0 || bus.dmem_we_o != d_we0 ||
                         bus.dmem_wdata_o != d_wdata0) begin
                d_unstable++;
            end
            d_rdy = (dcnt >= dmem_wait);
            if (d_rdy) begin
                if (bus.dmem_we_o) dmem[bus.dmem_addr_o[7:2]] = bus.dmem_wdata_o;
                else               d_rdata = dmem[bus.dmem_addr_o[7:2]];
            end
            dcnt++;
        end else begin
            d_rdy = 1'b0;
            dcnt  = 0;
        end
        if (halt && (bus.imem_req_o || bus.dmem_req_o)) req_in_halt++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_log = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clr_log = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", 32'(halt), 32'd1);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          delta;
    } fetch_vec_t;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } reg_vec_t;

    fetch_vec_t fv [12];
    reg_vec_t   rv [8];

    initial begin
        fv[0]  = '{32'h100, 4};  fv[1]  = '{32'h104, 4};  fv[2]  = '{32'h108, 4};
        fv[3]  = '{32'h10C, 4};  fv[4]  = '{32'h110, 4};  fv[5]  = '{32'h114, 7};
        fv[6]  = '{32'h118, 8};  fv[7]  = '{32'h11C, 4};  fv[8]  = '{32'h120, 3};
        fv[9]  = '{32'h020, 3};  fv[10] = '{32'h02C, 3};  fv[11] = '{32'h030, 0};
        rv[0] = '{0, 32'd0};  rv[1] = '{1, 32'd5};  rv[2] = '{2, 32'hFFFF_FFFD};
        rv[3] = '{3, 32'd2};  rv[4] = '{4, 32'd1};  rv[5] = '{5, 32'd80};
        rv[6] = '{6, 32'd5};  rv[7] = '{7, 32'd0};

        // Main program at the reset vector, branching into the low region.
        imem[64] = 32'h2001_0005;  // addi $1,$0,5
        imem[65] = 32'h2002_FFFD;  // addi $2,$0,-3
        imem[66] = 32'h0022_1820;  // add  $3,$1,$2
        imem[67] = 32'h0041_202A;  // slt  $4,$2,$1
        imem[68] = 32'h0001_2900;  // sll  $5,$1,4
        imem[69] = 32'hAC01_0008;  // sw   $1,8($0)
        imem[70] = 32'h8C06_0008;  // lw   $6,8($0)
        imem[71] = 32'h2000_0007;  // addi $0,$0,7
        imem[72] = 32'h0800_0008;  // j    0x20
        imem[8]  = 32'h1021_0002;  // 0x20 beq $1,$1,+2
        imem[9]  = 32'h2007_0001;  // 0x24 addi $7,$0,1 (skipped)
        imem[10] = 32'h2007_0002;  // 0x28 addi $7,$0,2 (skipped)
        imem[11] = 32'h1421_0002;  // 0x2C bne $1,$1,+2
        imem[12] = 32'hFC00_0000;  // 0x30 halt
        imem_wait = 0;
        dmem_wait = 3;

        do_reset();
        @(negedge clk);
        chk("rst_imem_req", 32'(bus.imem_req_o), 32'd1);
        chk("rst_imem_addr", bus.imem_addr_o, 32'h100);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req_o), 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_reg%0d", i), dut.regs_q[i], 32'd0);

        wait_halt(400);
        chk("prog_nfetch", 32'(nfetch), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("fetch_pc%0d", i), fetch_pc[i], fv[i].pc);
            if (i < 11) chk($sformatf("fetch_lat%0d", i), 32'(fetch_cyc[i+1] - fetch_cyc[i]), 32'(fv[i].delta));
        end
        for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", rv[i].idx), dut.regs_q[rv[i].idx], rv[i].val);
        chk("sw_addr", sw_addr, 32'd8);
        chk("sw_we", 32'(sw_we), 32'd1);
        chk("sw_wdata", sw_wdata, 32'd5);
        chk("dmem_accesses", 32'(dacc), 32'd2);
        chk("dmem_stable", 32'(d_unstable), 32'd0);
        chk("halt_op_illegal", 32'(illegal), 32'd0);
        repeat (10) @(negedge clk);
        chk("halt_no_req", 32'(req_in_halt), 32'd0);
        chk("halt_pc", pc, 32'h30);

        // bne not taken at 0x20.
        imem[64] = 32'h0800_0008;  // j 0x20
        imem[8]  = 32'h1400_0002;  // bne $0,$0,+2
        imem[9]  = 32'hFC00_0000;  // halt
        dmem_wait = 0;
        do_reset();
        wait_halt(100);
        chk("bne_fetch1", fetch_pc[1], 32'h20);
        chk("bne_fetch2", fetch_pc[2], 32'h24);
        chk("bne_lat", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd3);

        // j 0x40 loops back to the reset vector.
        imem[64] = 32'h0800_0040;
        do_reset();
        for (int n = 0; n < 40 && nfetch < 3; n++) @(negedge clk);
        chk("j_nfetch", 32'(nfetch >= 3), 32'd1);
        chk("j_fetch1", fetch_pc[1], 32'h100);
        chk("j_lat", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd3);

        // Unsupported opcode 0x11.
        imem[64] = 32'h4400_0000;
        do_reset();
        wait_halt(50);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_pc", pc, 32'h100);

        // Reset in the middle of a stalled store, then a stray ready.
        imem[64] = 32'hAC00_0000;  // sw $0,0($0)
        dmem_wait = 40;
        do_reset();
        for (int n = 0; n < 30 && !bus.dmem_req_o; n++) @(negedge clk);
        chk("mid_mem_req", 32'(bus.dmem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dreq", 32'(bus.dmem_req_o), 32'd0);
        chk("mid_rst_pc", pc, 32'h100);
        rst = 1'b0;
        d_force = 1'b1;
        @(negedge clk);
        d_force = 1'b0;
        chk("stray_rdy_pc", pc, 32'h100);
        chk("stray_rdy_dreq", 32'(bus.dmem_req_o), 32'd0);
        chk("stray_rdy_ireq", 32'(bus.imem_req_o), 32'd1);
        chk("stray_rdy_halt", 32'(halt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
- Multi-cycle MIPS-subset core; successor to the single-cycle CPU.
- Shares one ALU and register file over several states per instruction.
- Fetches from and loads/stores to external memories through req/ready handshakes, so instruction and data memories may have arbitrary latency.
- Adds load/store, jump, bne and halt, plus a configurable reset vector and register count.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NUM_REGS, 32: register file depth (power of two, 8..32); register addresses are truncated to log2(NUM_REGS) bits.
- HALT_OP, 6'h3F: opcode that stops the core.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  32  fetch byte address (= PC).
- imem_ready_i  in  1  fetch data valid this cycle.
- imem_rdata_i  in  32  instruction word.
- dmem_req_o  out  1  data access request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  32  data byte address.
- dmem_wdata_o  out  32  store data.
- dmem_ready_i  in  1  access complete (load data valid).
- dmem_rdata_i  in  32  load data.
- halt_o  out  1  core halted (HALT_OP or illegal opcode).
- illegal_o  out  1  halt was caused by an unsupported opcode or funct.
- pc_o  out  32  current PC, for debug.

Behaviour:
- Reset (rst_i=1 at an edge):
  - PC=RESET_PC, state=FETCH, all registers=0.
  - All req/we outputs 0, halt_o=0, illegal_o=0.
  - Reset overrides any outstanding request, and the next ready is ignored.
- States:
  - FETCH: imem_req_o=1 and imem_addr_o=PC, held stable until imem_ready_i=1. On ready, latch IR and go to DECODE.
  - DECODE: read rs/rt into A/B. Compute branch target = PC+4+(sext(imm)<<2) into the target register. Go to EXEC, or to HALT on HALT_OP or an illegal code.
  - EXEC: ALU operation into ALUOut.
    - beq/bne: PC = taken ? target : PC+4, then FETCH.
    - j: PC = {PC+4[31:28], IR[25:0], 2'b00}, then FETCH.
    - lw/sw: go to MEM.
    - All others: go to WB.
  - MEM: dmem_req_o=1, dmem_addr_o=ALUOut, dmem_we_o=(sw), dmem_wdata_o=B, all held until dmem_ready_i=1.
    - On ready, sw: PC+=4, then FETCH.
    - On ready, lw: latch MDR, then WB.
  - WB: write ALUOut (or MDR for lw) to rd (R-type) or rt (I-type). PC+=4, then FETCH.
  - HALT: terminal; halt_o=1 and no requests. Only rst_i leaves it.
- Latency with zero-wait memories:
  - branch/jump: 3 cycles.
  - R/I ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on ready adds 1 cycle.
- Supported instructions:
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02. sll/srl use shamt=IR[10:6] as the shift amount and rt as the value.
  - I-type: addi 0x08, slti 0x0A, ori 0x0D, beq 0x04, bne 0x05, lw 0x23, sw 0x2B, j 0x02.
  - ori zero-extends imm; every other I-type sign-extends.
  - Any other opcode or funct: illegal_o=1, then HALT.
- Arithmetic:
  - 32-bit two's complement with wrap, no overflow trap.
  - slt/slti compare signed.
  - The PC wraps modulo 2^32.
- Register 0: reads return 0 and writes are discarded.
- Reads in DECODE see all writes from earlier instructions. Instructions never overlap, so there are no hazards.
- Unaligned dmem/imem addresses are passed through unchecked; alignment is the memory's responsibility.
- A ready arriving in a cycle with no request is ignored.

Decomposition:
- Package mc_cpu_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
  - opcode/funct constants.
  - ALU-op enum.
- One sub-module, mc_cpu_alu: combinational ALU with ctrl, src1, src2, shamt inputs and result, zero outputs.
- The register file and FSM live in the top module.

Test Plan:
- Reset with RESET_PC=32'h100:
  - imem_addr_o=32'h100 with imem_req_o=1 one cycle after reset is released.
  - halt_o=0.
  - All registers read 0.
- Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sll $5,$1,4:
  - $3=2, $4=1, $5=80.
  - Each instruction takes 4 cycles from fetch request to next fetch request.
- sw $1,8($0) then lw $6,8($0) with 3-cycle dmem wait:
  - dmem_addr_o=8, dmem_we_o=1, dmem_wdata_o=5, held stable through the wait.
  - $6=5.
  - lw takes 8 cycles total.
- beq $1,$1,+2 at PC 0x20 -> next fetch at 0x2C.
- bne $1,$1,+2 at PC 0x20 -> next fetch at 0x24.
- j 0x40 -> next fetch at 0x100.
- addi $0,$0,7 -> $0 still reads 0.
- Opcode 6'h3F -> halt_o=1, illegal_o=0, no further requests.
- Opcode 6'h11 -> halt_o=1, illegal_o=1.
- Reset asserted mid-MEM with dmem_req_o=1 -> next cycle dmem_req_o=0, PC=RESET_PC, and a later dmem_ready_i pulse has no effect.
